// File: rtl/memory_operator_pkg.sv
// Shared constants for the byte-serial memory operator: opcodes, funct3 sizes,
// I/O window bounds and the instruction id width.
package memory_operator_pkg;

    localparam int CSU_SIZE_BITS = 3;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    localparam logic [31:0] IO_WIN_LO = 32'h0003_0000;
    localparam logic [31:0] IO_WIN_HI = 32'h0003_0007;

    // Byte count of an access; 0 marks an encoding with no memory access.
    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic logic in_io_window(input logic [31:0] a);
        return (a >= IO_WIN_LO) && (a <= IO_WIN_HI);
    endfunction

endpackage

// File: rtl/memory_operator_if.sv
// Dispatch, result and byte-serial RAM signals between the CSU/memory side
// (master) and the memory operator (slave).
interface memory_operator_if #(
    parameter int CSU_SIZE_BITS = memory_operator_pkg::CSU_SIZE_BITS
);
    logic                     is_executing;
    logic                     executing_ins_type;
    logic [CSU_SIZE_BITS-1:0] exec_ins_id;
    logic [6:0]               exec_opcode;
    logic [2:0]               exec_funct3;
    logic [31:0]              exec_imm_val;
    logic [31:0]              exec_rs1;
    logic [31:0]              exec_rs2;
    logic [31:0]              exec_PC;
    logic                     exec_is_compressed_ins;

    logic                     mo_busy;
    logic [31:0]              mo_res;
    logic                     mo_rdy;
    logic [CSU_SIZE_BITS-1:0] mo_res_ins_id;
    logic [31:0]              mo_completed_mo_resulting_PC;

    logic [7:0]               mem_din;
    logic [7:0]               mem_dout;
    logic [31:0]              mem_a;
    logic                     mem_wr;
    logic                     io_buffer_full;

    modport master (
        output is_executing, executing_ins_type, exec_ins_id, exec_opcode, exec_funct3,
               exec_imm_val, exec_rs1, exec_rs2, exec_PC, exec_is_compressed_ins,
               mem_din, io_buffer_full,
        input  mo_busy, mo_res, mo_rdy, mo_res_ins_id, mo_completed_mo_resulting_PC,
               mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  is_executing, executing_ins_type, exec_ins_id, exec_opcode, exec_funct3,
               exec_imm_val, exec_rs1, exec_rs2, exec_PC, exec_is_compressed_ins,
               mem_din, io_buffer_full,
        output mo_busy, mo_res, mo_rdy, mo_res_ins_id, mo_completed_mo_resulting_PC,
               mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/memory_operator_load_extender.sv
// Combinational size/sign extension of an assembled little-endian load word.
module load_extender
    import memory_operator_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);
    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'd0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/memory_operator.sv
// Byte-serial load/store unit: accepts one CSU memory op at a time, walks the
// bytes little-endian over the RAM port and reports the result for one cycle.
module memory_operator #(
    parameter int CSU_SIZE_BITS = memory_operator_pkg::CSU_SIZE_BITS
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic flush_pipline,
    memory_operator_if.slave bus
);
    import memory_operator_pkg::*;

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t                   state, state_n;
    logic [31:0]              addr_q, rs2_q, pc_q, data_q;
    logic [CSU_SIZE_BITS-1:0] id_q;
    logic [2:0]               f3_q, size_q, cnt_q;
    logic                     load_q, flushed_q;

    logic        accept, stall, last_store_byte;
    logic [2:0]  size_in;
    logic [31:0] byte_addr, ext;

    assign size_in         = access_bytes(bus.exec_funct3);
    assign accept          = bus.is_executing && bus.executing_ins_type &&
                             (state == IDLE) && !flush_pipline;
    assign byte_addr       = addr_q + 32'(cnt_q);
    assign stall           = bus.io_buffer_full && in_io_window(byte_addr);
    assign last_store_byte = !stall && (cnt_q == size_q - 3'd1);

    load_extender u_ext (
        .raw    (data_q),
        .funct3 (f3_q),
        .ext    (ext)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in)     state <= IDLE;
        else if (rdy_in) state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (size_in == 3'd0)                   state_n = DONE;
                    else if (bus.exec_opcode == OPC_LOAD)  state_n = LOAD;
                    else if (bus.exec_opcode == OPC_STORE) state_n = STORE;
                    else                                   state_n = DONE;
                end
            end
            LOAD: begin
                if (flush_pipline)         state_n = IDLE;
                else if (cnt_q == size_q)  state_n = DONE;
            end
            // A flushed store still completes every byte, then skips DONE.
            STORE: begin
                if (last_store_byte) state_n = (flushed_q || flush_pipline) ? IDLE : DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            addr_q    <= '0;
            rs2_q     <= '0;
            pc_q      <= '0;
            data_q    <= '0;
            id_q      <= '0;
            f3_q      <= '0;
            size_q    <= '0;
            cnt_q     <= '0;
            load_q    <= 1'b0;
            flushed_q <= 1'b0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= bus.exec_rs1 + bus.exec_imm_val;
                        rs2_q     <= bus.exec_rs2;
                        pc_q      <= bus.exec_PC + (bus.exec_is_compressed_ins ? 32'd2 : 32'd4);
                        id_q      <= bus.exec_ins_id;
                        f3_q      <= bus.exec_funct3;
                        size_q    <= size_in;
                        load_q    <= (bus.exec_opcode == OPC_LOAD) && (size_in != 3'd0);
                        cnt_q     <= '0;
                        data_q    <= '0;
                        flushed_q <= 1'b0;
                    end
                end
                // Read data lags its address by one cycle, so lane cnt-1 is captured.
                LOAD: begin
                    cnt_q <= cnt_q + 3'd1;
                    for (int unsigned k = 0; k < 4; k++)
                        if (cnt_q == 3'(k + 1)) data_q[8*k +: 8] <= bus.mem_din;
                end
                STORE: begin
                    flushed_q <= flushed_q | flush_pipline;
                    if (!stall) cnt_q <= cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_a    = '0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = '0;
        bus.mo_rdy   = 1'b0;
        bus.mo_res   = '0;
        case (state)
            LOAD: bus.mem_a = byte_addr;
            STORE: begin
                bus.mem_a  = byte_addr;
                bus.mem_wr = rdy_in && !stall;
                case (cnt_q[1:0])
                    2'd0:    bus.mem_dout = rs2_q[7:0];
                    2'd1:    bus.mem_dout = rs2_q[15:8];
                    2'd2:    bus.mem_dout = rs2_q[23:16];
                    default: bus.mem_dout = rs2_q[31:24];
                endcase
            end
            DONE: begin
                bus.mo_rdy = rdy_in && !flush_pipline;
                bus.mo_res = load_q ? ext : '0;
            end
            default: ;
        endcase
    end

    assign bus.mo_busy                      = (state != IDLE);
    assign bus.mo_res_ins_id                = id_q;
    assign bus.mo_completed_mo_resulting_PC = pc_q;

endmodule

// File: tb/tb_memory_operator.sv
// Directed bench for memory_operator: a byte RAM responder, an op-level model
// of results/latency/writes, and a per-cycle compare process.
module tb_memory_operator;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    memory_operator_if #(.CSU_SIZE_BITS(3)) bus();

    memory_operator #(.CSU_SIZE_BITS(3)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rdy_in        (rdy),
        .flush_pipline (flush),
        .bus           (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ram [logic [31:0]];

    logic        active = 1'b0;
    int          cyc, exp_rdy_cyc, busy_last, load_n, got_rdy_cyc, wr_seen, n_wr;
    logic [31:0] exp_res, exp_pc, load_base, last_res;
    logic [2:0]  exp_id;
    wr_t         exp_wr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a >= 32'h0003_0000) && (a <= 32'h0003_0007);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++) w = w | (32'(rd(a + 32'(k))) << (8 * k));
        case (f3)
            3'b000:  return 32'($signed(w[7:0]));
            3'b100:  return {24'd0, w[7:0]};
            3'b001:  return 32'($signed(w[15:0]));
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // RAM: an address seen in one cycle returns its data in the next.
    always begin : responder
        logic [31:0] a;
        logic [7:0]  d;
        logic        w;
        @(negedge clk);
        a = bus.mem_a;
        d = bus.mem_dout;
        w = bus.mem_wr;
        @(posedge clk);
        #1;
        if (w) ram[a] = d;
        bus.mem_din = rd(a);
    end

    always @(negedge clk) begin
        if (active) begin
            chk("busy", 32'(bus.mo_busy), 32'(cyc <= busy_last));
            chk("rdy", 32'(bus.mo_rdy), 32'(cyc == exp_rdy_cyc));
            if (bus.mo_rdy) begin
                got_rdy_cyc = cyc;
                last_res    = bus.mo_res;
                chk("res", bus.mo_res, exp_res);
                chk("res_id", 32'(bus.mo_res_ins_id), 32'(exp_id));
                chk("res_pc", bus.mo_completed_mo_resulting_PC, exp_pc);
            end
            if (bus.mem_wr) begin
                wr_seen++;
                if (exp_wr.size() > 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", bus.mem_a, e.a);
                    chk("wr_data", 32'(bus.mem_dout), 32'(e.d));
                end
            end
            if (!rdy) chk("wr_gated", 32'(bus.mem_wr), 32'd0);
            if (!bus.mo_busy) begin
                chk("idle_a", bus.mem_a, 32'd0);
                chk("idle_wr", 32'(bus.mem_wr), 32'd0);
            end
            if (cyc <= load_n && cyc <= busy_last)
                chk("load_a", bus.mem_a, load_base + 32'(cyc - 1));
        end
    end

    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] rs2, input logic [31:0] pc,
                          input logic comp, input logic [2:0] id,
                          input int flush_at, input int full_cycles, input int rdy_low_at);
        logic [31:0] addr;
        int          n, done, last;
        logic        is_ld, is_st, flushed;
        addr  = rs1 + imm;
        n     = nbytes(f3);
        is_ld = (opc == 7'b0000011) && (n != 0);
        is_st = (opc == 7'b0100011) && (n != 0);
        exp_wr.delete();
        wr_seen     = 0;
        n_wr        = 0;
        got_rdy_cyc = 0;
        exp_id      = id;
        exp_pc      = pc + (comp ? 32'd2 : 32'd4);
        exp_res     = is_ld ? model_load(addr, f3, n) : 32'd0;
        load_n      = is_ld ? n : 0;
        load_base   = addr;
        if (is_st) begin
            for (int k = 0; k < n; k++) begin
                wr_t e;
                e.a = addr + 32'(k);
                e.d = 8'(rs2 >> (8 * k));
                exp_wr.push_back(e);
            end
            n_wr = n;
        end
        // Cycle-level timeline: loads take N+2, stores advance one byte per unstalled ready cycle.
        if (is_ld) begin
            if (flush_at != 0 && flush_at <= n + 1) begin
                busy_last   = flush_at;
                exp_rdy_cyc = 0;
            end else begin
                exp_rdy_cyc = n + 2;
                busy_last   = n + 2;
            end
        end else if (is_st) begin
            done    = 0;
            flushed = 1'b0;
            for (int c = 1; c <= 64; c++) begin
                if (c == flush_at) flushed = 1'b1;
                if (c != rdy_low_at && !(c <= full_cycles && in_win(addr + 32'(done)))) done++;
                if (done == n) begin
                    if (flushed) begin
                        busy_last   = c;
                        exp_rdy_cyc = 0;
                    end else begin
                        exp_rdy_cyc = (c + 1 == rdy_low_at) ? c + 2 : c + 1;
                        busy_last   = exp_rdy_cyc;
                    end
                    break;
                end
            end
        end else begin
            exp_rdy_cyc = (rdy_low_at == 1) ? 2 : 1;
            busy_last   = exp_rdy_cyc;
        end

        @(posedge clk);
        #1;
        bus.is_executing           = 1'b1;
        bus.executing_ins_type     = 1'b1;
        bus.exec_ins_id            = id;
        bus.exec_opcode            = opc;
        bus.exec_funct3            = f3;
        bus.exec_imm_val           = imm;
        bus.exec_rs1               = rs1;
        bus.exec_rs2               = rs2;
        bus.exec_PC                = pc;
        bus.exec_is_compressed_ins = comp;
        @(posedge clk);
        #1;
        bus.is_executing = 1'b0;
        active = 1'b1;
        last = busy_last + 2;
        for (int c = 1; c <= last; c++) begin
            cyc = c;
            flush = (c == flush_at);
            bus.io_buffer_full = (c <= full_cycles);
            rdy = (c != rdy_low_at);
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        flush = 1'b0;
        bus.io_buffer_full = 1'b0;
        rdy = 1'b1;
        chk("write_count", 32'(wr_seen), 32'(n_wr));
        chk("rdy_cycle", 32'(got_rdy_cyc), 32'(exp_rdy_cyc));
    endtask

    initial begin
        bus.is_executing           = 1'b0;
        bus.executing_ins_type     = 1'b0;
        bus.exec_ins_id            = '0;
        bus.exec_opcode            = '0;
        bus.exec_funct3            = '0;
        bus.exec_imm_val           = '0;
        bus.exec_rs1               = '0;
        bus.exec_rs2               = '0;
        bus.exec_PC                = '0;
        bus.exec_is_compressed_ins = 1'b0;
        bus.mem_din                = '0;
        bus.io_buffer_full         = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.mo_busy), 32'd0);
        chk("rst_rdy", 32'(bus.mo_rdy), 32'd0);
        chk("rst_res", bus.mo_res, 32'd0);
        chk("rst_id", 32'(bus.mo_res_ins_id), 32'd0);
        chk("rst_pc", bus.mo_completed_mo_resulting_PC, 32'd0);
        chk("rst_a", bus.mem_a, 32'd0);
        chk("rst_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst_wr", 32'(bus.mem_wr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        ram[32'h104] = 8'h11; ram[32'h105] = 8'h22; ram[32'h106] = 8'h33; ram[32'h107] = 8'h44;
        ram[32'h20]  = 8'h80;
        ram[32'h40]  = 8'h34; ram[32'h41]  = 8'h92;

        run_op(7'b0000011, 3'b010, 32'h100, 32'd4, 32'd0, 32'h1000, 1'b0, 3'd5, 0, 0, 0);
        chk("lw_lit_res", last_res, 32'h4433_2211);
        chk("lw_lit_cycle", 32'(got_rdy_cyc), 32'd6);

        run_op(7'b0000011, 3'b000, 32'h30, 32'hFFFF_FFF0, 32'd0, 32'h1100, 1'b0, 3'd1, 0, 0, 0);
        chk("lb_lit_res", last_res, 32'hFFFF_FF80);
        run_op(7'b0000011, 3'b100, 32'h20, 32'd0, 32'd0, 32'h1104, 1'b0, 3'd2, 0, 0, 0);
        chk("lbu_lit_res", last_res, 32'h0000_0080);
        run_op(7'b0000011, 3'b001, 32'h40, 32'd0, 32'd0, 32'h1108, 1'b1, 3'd3, 0, 0, 0);
        chk("lh_lit_res", last_res, 32'hFFFF_9234);
        run_op(7'b0000011, 3'b101, 32'h40, 32'd0, 32'd0, 32'h110C, 1'b0, 3'd4, 0, 0, 0);
        chk("lhu_lit_res", last_res, 32'h0000_9234);

        run_op(7'b0100011, 3'b001, 32'd0, 32'd3, 32'hAABB_CCDD, 32'h2000, 1'b1, 3'd2, 0, 0, 0);
        chk("sh_lit_cycle", 32'(got_rdy_cyc), 32'd3);
        chk("sh_lit_ram3", 32'(rd(32'h3)), 32'h0000_00DD);
        chk("sh_lit_ram4", 32'(rd(32'h4)), 32'h0000_00CC);

        run_op(7'b0100011, 3'b000, 32'h0003_0000, 32'd0, 32'h0000_005A, 32'h2100, 1'b0, 3'd3, 0, 3, 0);
        chk("sb_io_lit_cycle", 32'(got_rdy_cyc), 32'd5);
        chk("sb_io_lit_ram", 32'(rd(32'h0003_0000)), 32'h0000_005A);

        run_op(7'b0000011, 3'b010, 32'h100, 32'd4, 32'd0, 32'h3000, 1'b0, 3'd6, 2, 0, 0);
        run_op(7'b0100011, 3'b010, 32'h200, 32'd0, 32'h0102_0304, 32'h3004, 1'b0, 3'd7, 2, 0, 0);
        chk("sw_flush_lit_ram", {rd(32'h203), rd(32'h202), rd(32'h201), rd(32'h200)}, 32'h0102_0304);

        run_op(7'b0000011, 3'b011, 32'h100, 32'd0, 32'd0, 32'h4000, 1'b0, 3'd1, 0, 0, 0);
        run_op(7'b0110011, 3'b000, 32'h100, 32'd0, 32'd0, 32'h4004, 1'b1, 3'd2, 0, 0, 0);

        run_op(7'b0100011, 3'b010, 32'h210, 32'd0, 32'hDEAD_BEEF, 32'h5000, 1'b0, 3'd3, 0, 0, 1);
        chk("sw_rdylow_lit_cycle", 32'(got_rdy_cyc), 32'd6);

        run_op(7'b0000011, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h6000, 1'b0, 3'd4, 0, 0, 0);
        chk("lw_wrap_lit_res", last_res, 32'hDD00_0000);

        // Dispatch coinciding with a flush in IDLE must be dropped.
        @(posedge clk);
        #1;
        bus.exec_opcode  = 7'b0000011;
        bus.exec_funct3  = 3'b010;
        bus.is_executing = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        bus.is_executing = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_drop_busy", 32'(bus.mo_busy), 32'd0);

        // Reset (with rdy_in low) in the second byte cycle of a word store.
        @(posedge clk);
        #1;
        bus.exec_opcode  = 7'b0100011;
        bus.exec_funct3  = 3'b010;
        bus.exec_rs1     = 32'h300;
        bus.exec_imm_val = 32'd0;
        bus.exec_rs2     = 32'h1122_3344;
        bus.exec_ins_id  = 3'd6;
        bus.exec_PC      = 32'h7000;
        bus.is_executing = 1'b1;
        @(posedge clk);
        #1;
        bus.is_executing = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(bus.mo_busy), 32'd0);
        chk("mrst_rdy", 32'(bus.mo_rdy), 32'd0);
        chk("mrst_res", bus.mo_res, 32'd0);
        chk("mrst_id", 32'(bus.mo_res_ins_id), 32'd0);
        chk("mrst_pc", bus.mo_completed_mo_resulting_PC, 32'd0);
        chk("mrst_a", bus.mem_a, 32'd0);
        chk("mrst_dout", 32'(bus.mem_dout), 32'd0);
        chk("mrst_wr", 32'(bus.mem_wr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_byte0", 32'(rd(32'h300)), 32'h0000_0044);
        chk("mrst_no_byte1", 32'(ram.exists(32'h301)), 32'd0);
        chk("mrst_no_byte2", 32'(ram.exists(32'h302)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_operator.md
MEMORY_OPERATOR -- requirements
Module: memory_operator

Interface
REQ-001 SHALL have parameter CSU_SIZE_BITS, default 3, meaning the width of the CSU instruction id.
REQ-002 SHALL have a single clock, clk_in (input, 1 bit), rising-edge; all state is updated on it.
REQ-003 SHALL have rst_in (input, 1 bit), synchronous, active-low reset.
REQ-004 SHALL have rdy_in (input, 1 bit); when low, all state is held.
REQ-005 SHALL have flush_pipline (input, 1 bit), the pipeline flush from the CSU.
REQ-006 SHALL have these dispatch inputs from the CSU:
- is_executing (1), executing_ins_type (1; 1 = memory op)
- exec_ins_id (CSU_SIZE_BITS)
- exec_opcode (7), exec_funct3 (3)
- exec_imm_val (32), exec_rs1 (32), exec_rs2 (32)
- exec_PC (32), exec_is_compressed_ins (1)
REQ-007 SHALL have output mo_busy (1), high whenever the unit is not in IDLE.
REQ-008 SHALL have these result outputs to the CSU: mo_res (32), mo_rdy (1), mo_res_ins_id (CSU_SIZE_BITS), mo_completed_mo_resulting_PC (32).
REQ-009 SHALL have this byte-serial RAM port: mem_din (input, 8), mem_dout (output, 8), mem_a (output, 32), mem_wr (output, 1; 1 = write), io_buffer_full (input, 1).

Function
REQ-010 SHALL accept an op on the rising edge where is_executing && executing_ins_type && !mo_busy && !flush_pipline; the CSU holds off dispatch while mo_busy.
REQ-011 SHALL latch at accept:
- address = exec_rs1 + exec_imm_val, modulo 2^32 (wrap-around permitted)
- id, funct3, exec_rs2
- resulting PC = exec_PC + (compressed ? 2 : 4)
REQ-012 SHALL decode size from funct3:
- 000 / 100 = 1 byte; 001 / 101 = 2 bytes; 010 = 4 bytes
- any other value completes with no memory access and mo_res = 0
REQ-013 SHALL implement states IDLE, LOAD, STORE, DONE: IDLE -> LOAD (opcode 0000011) or STORE (opcode 0100011); LOAD/STORE -> DONE after the last byte; DONE -> IDLE.
REQ-014 SHALL accept any other opcode by going directly to DONE with mo_res = 0.
REQ-015 LOAD SHALL drive mem_a = address + k for byte k, one byte per cycle; mem_din is valid one cycle after its address and is placed little-endian into byte lane k.
REQ-016 LOAD SHALL extend the result:
- sign-extend for LB/LH
- zero-extend for LBU/LHU
- LW returns the word unchanged
REQ-017 STORE SHALL drive mem_wr = 1 with mem_dout = byte k of rs2 at mem_a = address + k, one byte per cycle, little-endian.
REQ-018 STORE SHALL stall a byte without advancing while io_buffer_full = 1 and its address lies in 0x00030000-0x00030007.
REQ-019 SHALL assert mo_rdy in DONE for exactly one cycle, with mo_res, mo_res_ins_id and mo_completed_mo_resulting_PC valid in that cycle.
REQ-020 Stores SHALL return mo_res = 0.
REQ-021 Latency (rdy_in high, no stall, measured from the accept edge):
- load of N bytes: mo_rdy high in cycle N+2
- store of N bytes: mo_rdy high in cycle N+1
REQ-022 In IDLE and DONE the unit SHALL drive mem_wr = 0 and mem_a = 0.
REQ-023 Gating rules:
- mem_wr SHALL be forced to 0 whenever rdy_in = 0
- mo_rdy SHALL be 0 whenever rdy_in = 0
REQ-024 flush_pipline handling:
- in LOAD or DONE: return to IDLE next cycle with no mo_rdy
- in STORE: finish the remaining bytes, then return to IDLE with no mo_rdy (no partial stores)
REQ-025 If dispatch and flush coincide in IDLE, the flush SHALL win and the op SHALL be dropped.

Reset
REQ-026 When rst_in = 0 at a clock edge (regardless of rdy_in), the unit SHALL enter IDLE and zero all registers.
REQ-027 Reset values: mo_rdy = 0, mo_busy = 0, mo_res = 0, mo_res_ins_id = 0, mo_completed_mo_resulting_PC = 0, mem_a = 0, mem_dout = 0, mem_wr = 0.
REQ-028 Reset mid-store SHALL abandon any remaining bytes.

Structure
REQ-029 The shared package SHALL hold:
- CSU_SIZE_BITS
- opcode constants LOAD = 0000011 and STORE = 0100011
- funct3 encodings
- the I/O address window bounds
REQ-030 State encoding SHALL be local to the module.
REQ-031 A sub-module, load_extender (combinational size/sign extension), is natural.

Verification
REQ-032 LW: rs1 = 0x100, imm = 4, RAM[0x104..0x107] = 11 22 33 44, id = 5 -> mo_rdy in cycle 6, mo_res = 0x44332211, id = 5, resulting PC = PC + 4.
REQ-033 LB: RAM[0x20] = 0x80 -> mo_res = 0xFFFFFF80. LBU at the same address -> mo_res = 0x00000080.
REQ-034 SH: rs2 = 0xAABBCCDD, address 0x3 -> writes DD to 0x3 and CC to 0x4, mo_rdy in cycle 3, mo_res = 0; compressed op -> resulting PC = PC + 2.
REQ-035 SB to 0x30000 with io_buffer_full held high for 3 cycles -> mem_wr deasserted for those 3 cycles, mo_rdy at cycle 5.
REQ-036 Flush in the 2nd cycle of an LW -> no mo_rdy, IDLE next cycle; flush in the 2nd cycle of an SW -> all 4 bytes written, no mo_rdy.
REQ-037 rst_in = 0 during STORE -> all outputs return to their reset values next cycle; rs1 = 0xFFFFFFFF, imm = 1 -> access at 0x00000000.
